mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequences a single unified single-ported memory shared by the fetch stage (read-only) and the memory stage (read/write) of the 16-bit processor. Both stages issue requests and see stall and done signals. The arbiter grants one requester, launches one memory transaction, waits for the memory's completion pulse, and returns read data to the owner. It sits between `fetch`/`memory` and the memory macro inside `proc`.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `STARVE_LIMIT`, 4, number of consecutive data grants while fetch waits before fetch is forced; used only with the guard macro; legal range 1..15
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `f_req`  in  1  fetch read request; held until `f_done`
- `f_addr`  in  ADDR_W  fetch address; stable while `f_req`
- `f_done`  out  1  one-cycle pulse; `f_rdata` valid
- `f_rdata`  out  DATA_W  fetch read data
- `f_stall`  out  1  `f_req & ~f_done`
- `d_req`  in  1  data request; held until `d_done`
- `d_wr`  in  1  1 = store, 0 = load; stable while `d_req`
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_done`  out  1  one-cycle pulse; for loads, `d_rdata` valid
- `d_rdata`  out  DATA_W  load data
- `d_stall`  out  1  `d_req & ~d_done`
- `mem_en`  out  1  one-cycle launch strobe
- `mem_wr`  out  1  write qualifier; held while busy
- `mem_addr`  out  ADDR_W  registered address; held while busy
- `mem_wdata`  out  DATA_W  registered write data; held while busy
- `mem_done`  in  1  completion pulse; earliest 1 cycle after `mem_en`
- `mem_rdata`  in  DATA_W  valid with `mem_done`

## Operation
- States: IDLE, BUSY_F, BUSY_D. Encoding is one-hot.
- IDLE:
  - If `d_req`, go to BUSY_D. `d_req` wins when both requests are present.
  - Otherwise, if `f_req`, go to BUSY_F.
  - At the transition edge, capture the granted `addr`/`wr`/`wdata` into `mem_*` registers. Fetch grants force `mem_wr=0` and `mem_wdata=0`.
- BUSY_x:
  - `mem_en=1` only in the first cycle of the state. A registered `launched` flag tracks this.
  - When `mem_done=1`, assert the owner's `x_done` combinationally and drive `x_rdata = mem_rdata`. Next state is IDLE.
- Exactly one bubble cycle (IDLE) separates transactions.
- `f_rdata`/`d_rdata` are combinational pass-through, not held after `done`.
- `mem_done` in IDLE is ignored: no `done` pulse and no state change.
- Requester dropping `req` mid-transaction: the transaction still completes, and `done` still pulses.
- Store `done`: `d_rdata` is don't-care.

## Timing
- Reset values: state=IDLE, `mem_en=0`, `mem_wr=0`, `mem_addr=0`, `mem_wdata=0`, `f_done=d_done=0`, starve counter=0. `f_stall`/`d_stall` follow their equations.
- Minimum access, `req` at edge t:
  - t+1: BUSY, `mem_en=1`
  - t+2: earliest `mem_done`/`x_done`
  - t+3: IDLE
  - t+4: next launch
- `rst` mid-transaction: return to IDLE next edge. The in-flight access is abandoned, a late `mem_done` is ignored, and the requester re-requests.
- `rst` has priority over every event in the same cycle.
- The memory holds `mem_rdata` only during `mem_done`. The arbiter does not buffer it.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments on each data grant made while `f_req=1`. It clears on any fetch grant and on `rst`.
  - When count == `STARVE_LIMIT` and both requests are present in IDLE, fetch is granted.
- Not defined: strict data priority. No counter logic, and `STARVE_LIMIT` is unused.

## Structure
- Shared header `mem_arb_defs.vh` holds:
  - state encodings `ARB_IDLE`, `ARB_BUSY_F`, `ARB_BUSY_D`
  - grant codes `GNT_F`, `GNT_D`
  - default widths
- Sub-module `arb_starve_ctr` holds the saturating counter and the limit compare. It is instantiated only under the macro.
- The top holds the FSM, the capture registers and the `done`/`stall` logic.

## Test plan
- `f_req`, `f_addr=0x0010`, `mem_done` 3 cycles after `mem_en`, `mem_rdata=0xA5A5`:
  - `mem_en` one cycle with `mem_addr=0x0010`, `mem_wr=0`
  - `f_done` one cycle with `f_rdata=0xA5A5`
  - `f_stall` high for 4 cycles
- Simultaneous `f_req` (0x0020) and store `d_req` (`d_addr=0x0100`, `d_wdata=0x1234`):
  - data first: `mem_wr=1`, `mem_addr=0x0100`, `mem_wdata=0x1234`
  - after `d_done`, one IDLE cycle, then fetch launches at 0x0020
- Load `d_addr=0x0200`, `mem_done` 1 cycle after `mem_en`, `mem_rdata=0xBEEF` -> `d_done` with `d_rdata=0xBEEF` exactly 2 cycles after `req`.
- `rst` pulsed during BUSY_D, then `mem_done` arrives in IDLE -> no `d_done`, and outputs are at reset values.
- Macro on, `STARVE_LIMIT=2`, both requests held continuously -> grant order D, D, F, D, D, F.
- Macro off, same stimulus -> all grants D, with `f_stall` held high throughout.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state encodings, grant codes and default widths for the memory arbiter
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'b001,
        ARB_BUSY_F = 3'b010,
        ARB_BUSY_D = 3'b100
    } arbState_t;

    typedef enum logic {
        GNT_F = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// arb_starve_ctr: saturating 4-bit count of data grants made while fetch waits, with limit compare
// Ports: clk, rst (sync, active-high), inc (data grant with fetch waiting), clr (fetch grant), atLimit (count == LIMIT)
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic atLimit
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (inc && count != 4'hF)
            count <= count + 4'd1;
    end

    assign atLimit = count == 4'(LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants a single-ported memory to fetch (read-only) or data (read/write), one transaction at a time
// Ports: fetch f_req/f_addr -> f_done/f_rdata/f_stall; data d_req/d_wr/d_addr/d_wdata -> d_done/d_rdata/d_stall;
//        memory mem_en/mem_wr/mem_addr/mem_wdata -> mem_done/mem_rdata.
// Option: MEM_ARB_STARVE_GUARD_EN forces a fetch grant after STARVE_LIMIT data grants made while fetch waits.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata
);

    arbState_t state, stateNext;
    gnt_t      grant;
    logic      launched;
    logic      grantNow;
    logic      forceFetch;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic atLimit;
    arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) starveCtr (
        .clk     (clk),
        .rst     (rst),
        .inc     (grantNow && grant == GNT_D && f_req),
        .clr     (grantNow && grant == GNT_F),
        .atLimit (atLimit)
    );
    assign forceFetch = atLimit && f_req && d_req;
`else
    // Strict data priority; the limit only participates in a constant-false term
    assign forceFetch = STARVE_LIMIT < 0;
`endif

    always_comb begin
        grant     = (d_req && !forceFetch) ? GNT_D : GNT_F;
        grantNow  = state == ARB_IDLE && (d_req || f_req);
        stateNext = state;
        case (state)
            ARB_IDLE:   stateNext = grantNow ? (grant == GNT_D ? ARB_BUSY_D : ARB_BUSY_F) : ARB_IDLE;
            ARB_BUSY_F,
            ARB_BUSY_D: stateNext = mem_done ? ARB_IDLE : state;
            default:    stateNext = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            launched  <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state    <= stateNext;
            // Set after the launch cycle so mem_en strobes only once per BUSY visit
            launched <= state != ARB_IDLE && stateNext != ARB_IDLE;
            if (grantNow) begin
                mem_wr    <= grant == GNT_D ? d_wr : 1'b0;
                mem_addr  <= grant == GNT_D ? d_addr : f_addr;
                mem_wdata <= grant == GNT_D ? d_wdata : '0;
            end
        end
    end

    assign mem_en  = state != ARB_IDLE && !launched;
    assign f_done  = state == ARB_BUSY_F && mem_done;
    assign d_done  = state == ARB_BUSY_D && mem_done;
    assign f_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign f_stall = f_req && !f_done;
    assign d_stall = d_req && !d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (grant order depends on MEM_ARB_STARVE_GUARD_EN)
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, f_done, f_stall;
    logic [15:0] f_addr, f_rdata;
    logic        d_req, d_wr, d_done, d_stall;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_wr, mem_done;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_done    (f_done),
        .f_rdata   (f_rdata),
        .f_stall   (f_stall),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stallCnt;
        int waitc;
        logic expD;
        logic stallLow;
        rst = 1'b1; f_req = 0; f_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
        mem_done = 0; mem_rdata = 0;
        step(); step();
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_f_done", f_done, 0);
        check("rst_d_done", d_done, 0);
        check("rst_f_stall", f_stall, 0);
        check("rst_d_stall", d_stall, 0);
        rst = 0;
        step();

        // Fetch read, mem_done three cycles after the launch
        f_req = 1; f_addr = 16'h0010; stallCnt = 0;
        #1; stallCnt += int'(f_stall);
        check("f1_no_launch_idle", mem_en, 0);
        step(); stallCnt += int'(f_stall);
        check("f1_mem_en", mem_en, 1);
        check("f1_mem_addr", mem_addr, 16'h0010);
        check("f1_mem_wr", mem_wr, 0);
        step(); stallCnt += int'(f_stall);
        check("f1_mem_en_once", mem_en, 0);
        step(); stallCnt += int'(f_stall);
        check("f1_no_early_done", f_done, 0);
        step();
        mem_done = 1; mem_rdata = 16'hA5A5;
        #1; stallCnt += int'(f_stall);
        check("f1_f_done", f_done, 1);
        check("f1_f_rdata", f_rdata, 16'hA5A5);
        check("f1_stall_cycles", stallCnt, 4);
        step();
        mem_done = 0; f_req = 0;
        #1;
        check("f1_done_pulse", f_done, 0);
        check("f1_idle_no_en", mem_en, 0);
        step();

        // Simultaneous fetch and store: data wins, then one bubble, then fetch
        f_req = 1; f_addr = 16'h0020;
        d_req = 1; d_wr = 1; d_addr = 16'h0100; d_wdata = 16'h1234;
        step();
        check("s2_mem_en", mem_en, 1);
        check("s2_mem_wr", mem_wr, 1);
        check("s2_mem_addr", mem_addr, 16'h0100);
        check("s2_mem_wdata", mem_wdata, 16'h1234);
        check("s2_f_stall", f_stall, 1);
        step();
        mem_done = 1; mem_rdata = 16'h0000;
        #1;
        check("s2_d_done", d_done, 1);
        check("s2_f_done_low", f_done, 0);
        check("s2_d_stall_low", d_stall, 0);
        step();
        mem_done = 0; d_req = 0; d_wr = 0;
        #1;
        check("s2_bubble", mem_en, 0);
        step();
        check("s2_f_launch", mem_en, 1);
        check("s2_f_addr", mem_addr, 16'h0020);
        check("s2_f_wr", mem_wr, 0);
        check("s2_f_wdata", mem_wdata, 0);
        step();
        mem_done = 1; mem_rdata = 16'h5555;
        #1;
        check("s2_f_done", f_done, 1);
        check("s2_f_rdata", f_rdata, 16'h5555);
        step();
        mem_done = 0; f_req = 0;
        step();

        // Minimum-latency load
        d_req = 1; d_wr = 0; d_addr = 16'h0200;
        step();
        check("l3_mem_en", mem_en, 1);
        check("l3_mem_addr", mem_addr, 16'h0200);
        check("l3_mem_wr", mem_wr, 0);
        step();
        mem_done = 1; mem_rdata = 16'hBEEF;
        #1;
        check("l3_d_done", d_done, 1);
        check("l3_d_rdata", d_rdata, 16'hBEEF);
        step();
        mem_done = 0; d_req = 0;
        step();

        // Reset during BUSY_D, late mem_done ignored
        d_req = 1; d_wr = 1; d_addr = 16'h0300; d_wdata = 16'h7777;
        step();
        check("r4_mem_en", mem_en, 1);
        rst = 1; d_req = 0; d_wr = 0;
        step();
        rst = 0; mem_done = 1; mem_rdata = 16'h1111;
        #1;
        check("r4_no_d_done", d_done, 0);
        check("r4_mem_en", mem_en, 0);
        check("r4_mem_addr", mem_addr, 0);
        check("r4_mem_wr", mem_wr, 0);
        check("r4_mem_wdata", mem_wdata, 0);
        step();
        mem_done = 0;
        #1;
        check("r4_stay_idle", mem_en, 0);
        check("r4_no_f_done", f_done, 0);

        // Both requests held: grant order
        f_req = 1; f_addr = 16'h00F0;
        d_req = 1; d_wr = 0; d_addr = 16'h00D0;
        stallLow = 0;
        for (int g = 0; g < 6; g++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            expD = (g % 3) != 2;
`else
            expD = 1'b1;
`endif
            waitc = 0;
            while (!mem_en && waitc < 10) begin
                step();
                waitc++;
                stallLow |= !f_stall;
            end
            check($sformatf("g%0d_launch_in_time", g), waitc < 10, 1);
            check($sformatf("g%0d_grant_addr", g), mem_addr, expD ? 16'h00D0 : 16'h00F0);
            step();
            stallLow |= !f_stall;
            mem_done = 1; mem_rdata = 16'h4000 + 16'(g);
            #1;
            check($sformatf("g%0d_owner_done", g), {d_done, f_done}, expD ? 2'b10 : 2'b01);
            step();
            mem_done = 0;
            #1;
            stallLow |= !f_stall;
        end
`ifndef MEM_ARB_STARVE_GUARD_EN
        check("g_f_stall_held", stallLow, 0);
`endif
        f_req = 0; d_req = 0;
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
